// File: rtl/sysu_bcd_display_counter_if.sv
// Bus bundle for sysu_bcd_display_counter.
// Carries the divided tick input, the count controls (en, up, load, load_val)
// and the display-side outputs (bcd, tc, an, seg, dp).
//   master : drives tick/control, observes count and display
//   slave  : the counter itself
interface sysu_bcd_display_counter_if;
  logic        tick_in;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] bcd;
  logic        tc;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output tick_in, en, up, load, load_val,
    input  bcd, tc, an, seg, dp
  );

  modport slave (
    input  tick_in, en, up, load, load_val,
    output bcd, tc, an, seg, dp
  );
endinterface

// File: rtl/sysu_bcd_display_counter.sv
// Four-digit BCD up/down counter with a multiplexed common-anode
// seven-segment driver.
// Ports:
//   clk_in : fast system clock; everything runs in this domain
//   rst    : asynchronous, active-high reset
//   bus    : slave side of sysu_bcd_display_counter_if
//            tick_in (async square wave, rising edge = count event),
//            en, up, load, load_val[15:0] in;
//            bcd[15:0], tc, an[3:0], seg[6:0] {g..a}, dp out (all registered,
//            display signals active-low)
module sysu_bcd_display_counter #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input logic                        clk_in,
  input logic                        rst,
  sysu_bcd_display_counter_if.slave  bus
);

  localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

  logic        sync1_r;
  logic        sync2_r;
  logic        hist_r;
  logic [2:0]  prime_r;
  logic        tick_p_s;
  logic [15:0] bcd_r;
  logic        tc_r;
  logic [15:0] next_bcd_s;
  logic        next_tc_s;
  logic [19:0] scan_cnt_r;
  logic [1:0]  digit_idx_r;
  logic [3:0]  digit_s;
  logic [3:0]  an_next_s;
  logic [3:0]  an_r;
  logic [6:0]  seg_r;
  logic        dp_r;

  // Clamp every nibble to at most 9.
  function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Decimal increment; MSB of the result is the carry out of digit 3.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return {c, r};
  endfunction

  // Decimal decrement; MSB of the result is the borrow out of digit 3.
  function automatic logic [16:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return {b, r};
  endfunction

  // Active-low {g..a} pattern for one digit.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Tick synchroniser and edge history. prime_r marks when hist_r holds a
  // genuine post-reset sample, so a tick_in that is already high at reset
  // release must go low and high again before it counts.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      hist_r  <= 1'b0;
      prime_r <= 3'b000;
    end else begin
      sync1_r <= bus.tick_in;
      sync2_r <= sync1_r;
      hist_r  <= sync2_r;
      prime_r <= {prime_r[1:0], 1'b1};
    end
  end

  assign tick_p_s = sync2_r & ~hist_r & prime_r[2];

  // Next count: load beats tick; tick only counts when enabled.
  always_comb begin
    next_bcd_s = bcd_r;
    next_tc_s  = 1'b0;
    if (bus.load) begin
      next_bcd_s = bcd_clamp(bus.load_val);
    end else if (tick_p_s && bus.en) begin
      if (bus.up) begin
        {next_tc_s, next_bcd_s} = bcd_inc(bcd_r);
      end else begin
        {next_tc_s, next_bcd_s} = bcd_dec(bcd_r);
      end
    end else begin
      next_bcd_s = bcd_r;
      next_tc_s  = 1'b0;
    end
  end

  // Count and terminal-count registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      bcd_r <= 16'h0000;
      tc_r  <= 1'b0;
    end else begin
      bcd_r <= next_bcd_s;
      tc_r  <= next_tc_s;
    end
  end

  // Free-running scan timer; each wrap moves to the next digit.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      scan_cnt_r  <= 20'd0;
      digit_idx_r <= 2'd0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r  <= 20'd0;
      digit_idx_r <= digit_idx_r + 2'd1;
    end else begin
      scan_cnt_r  <= scan_cnt_r + 20'd1;
    end
  end

  // Digit and anode selection for the current scan position.
  always_comb begin
    digit_s   = bcd_r[3:0];
    an_next_s = 4'b1110;
    case (digit_idx_r)
      2'd0:    begin digit_s = bcd_r[3:0];   an_next_s = 4'b1110; end
      2'd1:    begin digit_s = bcd_r[7:4];   an_next_s = 4'b1101; end
      2'd2:    begin digit_s = bcd_r[11:8];  an_next_s = 4'b1011; end
      2'd3:    begin digit_s = bcd_r[15:12]; an_next_s = 4'b0111; end
      default: begin digit_s = bcd_r[3:0];   an_next_s = 4'b1110; end
    endcase
  end

  // Registered display drive.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      an_r  <= 4'b1110;
      seg_r <= 7'b1000000;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_code(digit_s);
      dp_r  <= 1'b1;
    end
  end

  assign bus.bcd = bcd_r;
  assign bus.tc  = tc_r;
  assign bus.an  = an_r;
  assign bus.seg = seg_r;
  assign bus.dp  = dp_r;

endmodule
